// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM state encoding,
// StallBus layout with its Stop/NoStop values, the stall vectors driven onto
// it, exception codes and performance-counter select indices.
package pipe_ctrl_pkg;

    // StallBus: bit 0 = PC, bit 5 = WB. A set bit means the stage holds.
    typedef logic [5:0] stall_bus_t;
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_IF   = 6'b000011;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;
    localparam stall_bus_t STALL_MEM  = 6'b011111;
    localparam stall_bus_t STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    localparam logic [31:0] EXC_ERET        = 32'h0000_000e;
    localparam logic [31:0] EXC_VEC_DEFAULT = 32'hBFC0_0380;

    // Performance counter selects; selects at or above PERF_NUM read 0.
    localparam int PERF_SEL_MEM   = 0;
    localparam int PERF_SEL_EX    = 1;
    localparam int PERF_SEL_ID    = 2;
    localparam int PERF_SEL_IF    = 3;
    localparam int PERF_SEL_FLUSH = 4;
    localparam int PERF_NUM       = 5;

endpackage

// File: rtl/perf_cnt_bank.sv
// Bank of wrapping 32-bit event counters with a select-driven read mux.
// Only instantiated by pipe_ctrl when PIPE_CTRL_PERF_EN is defined.
module perf_cnt_bank
    import pipe_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic [PERF_NUM-1:0] inc,
    input  logic [2:0]          sel,
    output logic [31:0]         rdata
);

    logic [31:0] cnt_q [PERF_NUM];

    // Count one event per asserted increment bit each cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: this array is reset on purpose (counters must read 0 after reset);
            // plain storage arrays are normally left unreset so they map to RAM.
            for (int i = 0; i < PERF_NUM; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < PERF_NUM; i++) begin
                if (inc[i]) cnt_q[i] <= cnt_q[i] + 32'd1;
            end
        end
    end

    // Read mux; unpopulated selects return zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < PERF_NUM; i++) begin
            if (sel == 3'(i)) rdata = cnt_q[i];
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges per-stage stall requests into the StallBus,
// runs the RUN -> FREEZE -> FLUSH (-> DRAIN) precise-exception sequence and
// supplies the redirect PC. Optional counters: define PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEFAULT,
    parameter int unsigned DRAIN_MAX = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_mem,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    input  logic [2:0]  perf_sel,
    output logic [31:0] perf_rdata
);

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MAX - 1);

    state_e      state_q,     state_d;
    logic [31:0] new_pc_q,    new_pc_d;
    logic [3:0]  drain_cnt_q, drain_cnt_d;
    stall_bus_t  stall_raw;
    logic        flush_raw;
    logic        exc_take;

    // An exception under an outstanding MEM transaction waits for it to finish.
    assign exc_take = (excepttype_mem != '0) && !stallreq_mem;

    // State register, latched redirect target and drain counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_RUN;
            new_pc_q    <= '0;
            drain_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            new_pc_q    <= new_pc_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state logic and Moore/Mealy outputs.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_d     = state_q;
        new_pc_d    = new_pc_q;
        drain_cnt_d = drain_cnt_q;
        stall_raw   = STALL_NONE;
        flush_raw   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (exc_take) begin
                    stall_raw = STALL_ALL;
                    state_d   = ST_FREEZE;
                    new_pc_d  = (excepttype_mem == EXC_ERET) ? cp0_epc : EXC_VEC;
                end else if (stallreq_mem) begin
                    stall_raw = STALL_MEM;
                end else if (stallreq_ex) begin
                    stall_raw = STALL_EX;
                end else if (stallreq_id) begin
                    stall_raw = STALL_ID;
                end else if (stallreq_if) begin
                    stall_raw = STALL_IF;
                end
            end
            ST_FREEZE: begin
                stall_raw = STALL_ALL;
                state_d   = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_raw   = 1'b1;
                drain_cnt_d = '0;
                state_d     = stallreq_if ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
                // Hold PC/IC while a wrong-path refill completes; bounded wait.
                stall_raw = STALL_IF;
                if (!stallreq_if || drain_cnt_q == DRAIN_LAST) begin
                    state_d     = ST_RUN;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Requests are combinational in RUN, so mask them while reset is held.
    assign stall  = resetn ? stall_raw : STALL_NONE;
    assign flush  = flush_raw;
    assign new_pc = flush_raw ? new_pc_q : '0;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_NUM-1:0] perf_inc;

    // Attribute each stalled cycle to the request that caused it.
    always_comb begin
        perf_inc = '0;
        if (state_q == ST_RUN && !exc_take) begin
            if (stallreq_mem)     perf_inc[PERF_SEL_MEM] = 1'b1;
            else if (stallreq_ex) perf_inc[PERF_SEL_EX]  = 1'b1;
            else if (stallreq_id) perf_inc[PERF_SEL_ID]  = 1'b1;
            else if (stallreq_if) perf_inc[PERF_SEL_IF]  = 1'b1;
        end else if (state_q == ST_DRAIN) begin
            perf_inc[PERF_SEL_IF] = 1'b1;
        end
        perf_inc[PERF_SEL_FLUSH] = flush_raw;
    end

    perf_cnt_bank u_perf_cnt_bank (
        .clk    (clk),
        .resetn (resetn),
        .inc    (perf_inc),
        .sel    (perf_sel),
        .rdata  (perf_rdata)
    );
`else
    logic unused_perf_sel;
    assign unused_perf_sel = ^perf_sel;
    assign perf_rdata      = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are checked 3 units later, mid-cycle.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype_mem, cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [2:0]  perf_sel;
    logic [31:0] perf_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .stallreq_if    (stallreq_if),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .excepttype_mem (excepttype_mem),
        .cp0_epc        (cp0_epc),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .perf_sel       (perf_sel),
        .perf_rdata     (perf_rdata)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the three main outputs for the current cycle, then advance.
    task automatic cyc(input string tag, input logic [5:0] exp_stall,
                       input logic exp_flush, input logic [31:0] exp_pc);
        #3;
        check({tag, ".stall"}, {26'd0, stall}, {26'd0, exp_stall});
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, exp_flush});
        check({tag, ".new_pc"}, new_pc, exp_pc);
        tick();
    endtask

    task automatic set_req(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem);
        stallreq_if  = r_if;
        stallreq_id  = r_id;
        stallreq_ex  = r_ex;
        stallreq_mem = r_mem;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        set_req(0, 0, 0, 0);
        excepttype_mem = '0;
        cp0_epc        = '0;
        perf_sel       = 3'd0;

        // Reset values
        tick();
        tick();
        cyc("reset", 6'h00, 1'b0, 32'h0);
        check("reset.perf", perf_rdata, 32'h0);
        resetn = 1'b1;

        // Single requests and priority
        set_req(1, 0, 0, 0); cyc("req_if",  6'b000011, 1'b0, 32'h0);
        set_req(0, 1, 0, 0); cyc("req_id",  6'b000111, 1'b0, 32'h0);
        set_req(0, 0, 1, 0); cyc("req_ex",  6'b001111, 1'b0, 32'h0);
        set_req(0, 0, 0, 1); cyc("req_mem", 6'b011111, 1'b0, 32'h0);
        set_req(1, 1, 1, 1); cyc("req_all", 6'b011111, 1'b0, 32'h0);
        set_req(1, 1, 0, 0); cyc("req_ifid", 6'b000111, 1'b0, 32'h0);

        // EX + ID together for 3 cycles, then released
        set_req(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc("exid", 6'b001111, 1'b0, 32'h0);
        set_req(0, 0, 0, 0);
        cyc("exid_rel", 6'h00, 1'b0, 32'h0);

        // Syscall: N stall all, N+1 freeze, N+2 flush to vector, N+3 RUN
        excepttype_mem = 32'h8;
        cyc("sys_n",  6'h3F, 1'b0, 32'h0);
        excepttype_mem = '0;
        cyc("sys_n1", 6'h3F, 1'b0, 32'h0);
        cyc("sys_n2", 6'h00, 1'b1, 32'hBFC0_0380);
        set_req(0, 1, 0, 0);
        cyc("sys_n3", 6'b000111, 1'b0, 32'h0);
        set_req(0, 0, 0, 0);

        // ERET redirects to EPC
        excepttype_mem = 32'he;
        cp0_epc        = 32'h8000_1234;
        cyc("eret_n",  6'h3F, 1'b0, 32'h0);
        excepttype_mem = '0;
        cp0_epc        = 32'h0;
        cyc("eret_n1", 6'h3F, 1'b0, 32'h0);
        cyc("eret_n2", 6'h00, 1'b1, 32'h8000_1234);
        cyc("eret_n3", 6'h00, 1'b0, 32'h0);

        // Exception held off by an outstanding MEM transaction
        excepttype_mem = 32'h8;
        set_req(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc("memblk", 6'b011111, 1'b0, 32'h0);
        set_req(0, 0, 0, 0);
        cyc("memblk_n", 6'h3F, 1'b0, 32'h0);
        excepttype_mem = '0;
        cyc("memblk_n1", 6'h3F, 1'b0, 32'h0);
        cyc("memblk_n2", 6'h00, 1'b1, 32'hBFC0_0380);

        // Drain: stallreq_if held through FLUSH; forced exit after 15 cycles.
        // A pending exception is ignored in DRAIN and taken once back in RUN.
        excepttype_mem = 32'h8;
        set_req(1, 0, 0, 0);
        cyc("drn_n",  6'h3F, 1'b0, 32'h0);
        excepttype_mem = '0;
        cyc("drn_n1", 6'h3F, 1'b0, 32'h0);
        cyc("drn_flush", 6'h00, 1'b1, 32'hBFC0_0380);
        excepttype_mem = 32'h8;
        for (int i = 0; i < 15; i++) cyc("drain", 6'b000011, 1'b0, 32'h0);
        cyc("drain_exit", 6'h3F, 1'b0, 32'h0);
        excepttype_mem = '0;
        set_req(0, 0, 0, 0);
        cyc("drain_frz", 6'h3F, 1'b0, 32'h0);
        cyc("drain_fl2", 6'h00, 1'b1, 32'hBFC0_0380);
        cyc("drain_run", 6'h00, 1'b0, 32'h0);

`ifdef PIPE_CTRL_PERF_EN
        perf_sel = 3'd4;
        #1 check("perf_flush", perf_rdata, 32'd5);
        perf_sel = 3'd6;
        #1 check("perf_sel6", perf_rdata, 32'd0);
        tick();
`else
        for (int s = 0; s < 8; s++) begin
            perf_sel = 3'(s);
            #1 check("perf_off", perf_rdata, 32'd0);
        end
        tick();
`endif

        // Reset during FREEZE aborts the sequence with no flush afterwards
        excepttype_mem = 32'h8;
        cyc("rst_n", 6'h3F, 1'b0, 32'h0);
        excepttype_mem = '0;
        #3;
        check("rst_frz.stall", {26'd0, stall}, 32'h3F);
        resetn = 1'b0;
        #1;
        check("rst_now.stall", {26'd0, stall}, 32'h0);
        check("rst_now.flush", {31'd0, flush}, 32'h0);
        check("rst_now.new_pc", new_pc, 32'h0);
        tick();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) cyc("post_rst", 6'h00, 1'b0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        for (int s = 0; s < 8; s++) begin
            perf_sel = 3'(s);
            #1 check("perf_rst", perf_rdata, 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
